// File: rtl/pipe_beat_serializer.sv
// Message-word to 32-bit beat serializer.
// One held word; header beat first, then up to three payload beats.
module pipe_beat_serializer #(
  parameter int MSG_WIDTH  = 144,
  parameter int BEAT_WIDTH = 32,
  parameter int MAX_BEATS  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [MSG_WIDTH-1:0]  pipe_enq_v,
  input  logic                  pipe_enq_ena,
  output logic                  pipe_enq_rdy,
  output logic [BEAT_WIDTH-1:0] beat_data,
  output logic                  beat_valid,
  output logic                  beat_last,
  input  logic                  beat_ready,
  output logic                  err_len,
  output logic [CNT_WIDTH-1:0]  msg_count
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  localparam int HW = MSG_WIDTH - 16;

  state_t                state_q, state_d;
  logic [HW-1:0]         word_q, word_d;
  logic [2:0]            n_q, n_d;
  logic [1:0]            idx_q, idx_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [BEAT_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic       fire;
  logic       last_fire;
  logic       rdy;
  logic       accept;
  logic [15:0] len;
  logic       len_bad;
  logic [2:0] n_new;
  logic [1:0] idx_nx;

  // Header is word_q[127:96]; payload Pk sits 32 bits lower per k.
  function automatic logic [BEAT_WIDTH-1:0] beat_sel(
    input logic [HW-1:0] w,
    input logic [1:0]    i
  );
    logic [BEAT_WIDTH-1:0] r;
    r = w[127:96];
    unique case (i)
      2'd0: r = w[127:96];
      2'd1: r = w[95:64];
      2'd2: r = w[63:32];
      2'd3: r = w[31:0];
    endcase
    return r;
  endfunction

  always_comb begin
    fire      = valid_q && beat_ready;
    last_fire = fire && last_q;
    rdy       = (state_q == IDLE) || last_fire;
    accept    = pipe_enq_ena && rdy;
    len       = pipe_enq_v[15:0];
    len_bad   = (len == 16'd0) || (len > 16'(MAX_BEATS));
    n_new     = len[2:0];
    if (len == 16'd0) begin
      n_new = 3'd1;
    end else if (len > 16'(MAX_BEATS)) begin
      n_new = 3'(MAX_BEATS);
    end
    idx_nx = idx_q + 2'd1;

    state_d = state_q;
    word_d  = word_q;
    n_d     = n_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    data_d  = data_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    if (last_fire) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (accept) begin
      state_d = SEND;
      word_d  = pipe_enq_v[MSG_WIDTH-1:16];
      n_d     = n_new;
      idx_d   = 2'd0;
      valid_d = 1'b1;
      last_d  = (n_new == 3'd1);
      data_d  = pipe_enq_v[MSG_WIDTH-1:MSG_WIDTH-BEAT_WIDTH];
      err_d   = len_bad;
    end else if (last_fire) begin
      state_d = IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (fire) begin
      idx_d  = idx_nx;
      data_d = beat_sel(word_q, idx_nx);
      last_d = ({1'b0, idx_nx} == (n_q - 3'd1));
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      word_q  <= '0;
      n_q     <= 3'd1;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pipe_enq_rdy = rdy;
  assign beat_data    = data_q;
  assign beat_valid   = valid_q;
  assign beat_last    = last_q;
  assign err_len      = err_q;
  assign msg_count    = cnt_q;

endmodule

// File: tb/tb_pipe_beat_serializer.sv
// Directed bench for pipe_beat_serializer.
// Vector table plus hand sequences for reset and restart.
module tb_pipe_beat_serializer;

  logic         CLK;
  logic         nRST;
  logic [143:0] pipe_enq_v;
  logic         pipe_enq_ena;
  logic         pipe_enq_rdy;
  logic [31:0]  beat_data;
  logic         beat_valid;
  logic         beat_last;
  logic         beat_ready;
  logic         err_len;
  logic [15:0]  msg_count;

  int checks;
  int failures;

  pipe_beat_serializer dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .pipe_enq_v   (pipe_enq_v),
    .pipe_enq_ena (pipe_enq_ena),
    .pipe_enq_rdy (pipe_enq_rdy),
    .beat_data    (beat_data),
    .beat_valid   (beat_valid),
    .beat_last    (beat_last),
    .beat_ready   (beat_ready),
    .err_len      (err_len),
    .msg_count    (msg_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         ena;
    logic [143:0] v;
    logic         rin;
    logic         cd;
    logic [31:0]  d;
    logic         vl;
    logic         ls;
    logic         rd;
    logic         er;
    logic [15:0]  cnt;
  } vec_t;

  vec_t tv[18];

  function automatic logic [143:0] mk(
    input logic [15:0] m, input logic [15:0] p,
    input logic [31:0] p0, input logic [31:0] p1,
    input logic [31:0] p2, input logic [15:0] l
  );
    return {m, p, p0, p1, p2, l};
  endfunction

  function automatic vec_t mv(
    input logic ena, input logic [143:0] v, input logic rin,
    input logic cd, input logic [31:0] d, input logic vl,
    input logic ls, input logic rd, input logic er,
    input logic [15:0] cnt
  );
    vec_t t;
    t.ena = ena; t.v = v; t.rin = rin; t.cd = cd; t.d = d;
    t.vl = vl; t.ls = ls; t.rd = rd; t.er = er; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [143:0] w1, w2, w3, w4;

  initial begin
    checks = 0;
    failures = 0;
    nRST = 1'b0;
    pipe_enq_v = '0;
    pipe_enq_ena = 1'b0;
    beat_ready = 1'b0;

    w1 = mk(16'h0, 16'h5, 32'hDEADBEEF, 32'h0, 32'h0, 16'd2);
    w2 = mk(16'h2, 16'h5, 32'h11111111, 32'h22222222,
            32'h33333333, 16'd4);
    w3 = mk(16'h7, 16'h9, 32'h0BADF00D, 32'h0, 32'h0, 16'd0);
    w4 = mk(16'h3, 16'h4, 32'hA1A1A1A1, 32'hB2B2B2B2,
            32'hC3C3C3C3, 16'd9);

    tv[0]  = mv(1, w1, 1, 0, 32'h0,        0, 0, 1, 0, 16'd0);
    tv[1]  = mv(0, '0, 1, 1, 32'h00000005, 1, 0, 0, 0, 16'd0);
    tv[2]  = mv(0, '0, 1, 1, 32'hDEADBEEF, 1, 1, 1, 0, 16'd0);
    tv[3]  = mv(0, '0, 1, 0, 32'h0,        0, 0, 1, 0, 16'd1);
    tv[4]  = mv(1, w2, 1, 0, 32'h0,        0, 0, 1, 0, 16'd1);
    tv[5]  = mv(0, '0, 1, 1, 32'h00020005, 1, 0, 0, 0, 16'd1);
    tv[6]  = mv(0, '0, 1, 1, 32'h11111111, 1, 0, 0, 0, 16'd1);
    tv[7]  = mv(0, '0, 0, 1, 32'h22222222, 1, 0, 0, 0, 16'd1);
    tv[8]  = mv(1, w1, 0, 1, 32'h22222222, 1, 0, 0, 0, 16'd1);
    tv[9]  = mv(0, '0, 0, 1, 32'h22222222, 1, 0, 0, 0, 16'd1);
    tv[10] = mv(0, '0, 1, 1, 32'h22222222, 1, 0, 0, 0, 16'd1);
    tv[11] = mv(1, w3, 1, 1, 32'h33333333, 1, 1, 1, 0, 16'd1);
    tv[12] = mv(1, w4, 1, 1, 32'h00070009, 1, 1, 1, 1, 16'd2);
    tv[13] = mv(0, '0, 1, 1, 32'h00030004, 1, 0, 0, 1, 16'd3);
    tv[14] = mv(0, '0, 1, 1, 32'hA1A1A1A1, 1, 0, 0, 0, 16'd3);
    tv[15] = mv(0, '0, 1, 1, 32'hB2B2B2B2, 1, 0, 0, 0, 16'd3);
    tv[16] = mv(0, '0, 1, 1, 32'hC3C3C3C3, 1, 1, 1, 0, 16'd3);
    tv[17] = mv(0, '0, 1, 0, 32'h0,        0, 0, 1, 0, 16'd4);

    #12;
    chk("rst_valid", 32'(beat_valid), 32'd0);
    chk("rst_last",  32'(beat_last),  32'd0);
    chk("rst_data",  beat_data,       32'd0);
    chk("rst_err",   32'(err_len),    32'd0);
    chk("rst_cnt",   32'(msg_count),  32'd0);
    chk("rst_rdy",   32'(pipe_enq_rdy), 32'd1);
    tick();
    nRST = 1'b1;

    for (int i = 0; i < 18; i++) begin
      pipe_enq_ena = tv[i].ena;
      pipe_enq_v   = tv[i].v;
      beat_ready   = tv[i].rin;
      #1;
      if (tv[i].cd)
        chk($sformatf("v%0d_data", i), beat_data, tv[i].d);
      chk($sformatf("v%0d_valid", i), 32'(beat_valid), 32'(tv[i].vl));
      chk($sformatf("v%0d_last", i),  32'(beat_last),  32'(tv[i].ls));
      chk($sformatf("v%0d_rdy", i),   32'(pipe_enq_rdy), 32'(tv[i].rd));
      chk($sformatf("v%0d_err", i),   32'(err_len),    32'(tv[i].er));
      chk($sformatf("v%0d_cnt", i),   32'(msg_count),  32'(tv[i].cnt));
      tick();
    end

    // Reset in the middle of a 4-beat message.
    pipe_enq_ena = 1'b1;
    pipe_enq_v   = w2;
    beat_ready   = 1'b1;
    tick();
    pipe_enq_ena = 1'b0;
    tick();
    chk("mid_beat1", beat_data, 32'h11111111);
    chk("mid_cnt_pre", 32'(msg_count), 32'd4);
    nRST = 1'b0;
    #1;
    chk("mid_valid", 32'(beat_valid), 32'd0);
    chk("mid_last",  32'(beat_last),  32'd0);
    chk("mid_cnt",   32'(msg_count),  32'd0);
    chk("mid_rdy",   32'(pipe_enq_rdy), 32'd1);
    tick();
    nRST = 1'b1;
    #1;
    chk("post_valid", 32'(beat_valid), 32'd0);
    pipe_enq_ena = 1'b1;
    pipe_enq_v   = w1;
    tick();
    pipe_enq_ena = 1'b0;
    chk("post_b0",  beat_data, 32'h00000005);
    chk("post_v0",  32'(beat_valid), 32'd1);
    chk("post_l0",  32'(beat_last),  32'd0);
    tick();
    chk("post_b1",  beat_data, 32'hDEADBEEF);
    chk("post_l1",  32'(beat_last), 32'd1);
    tick();
    chk("post_idle", 32'(beat_valid), 32'd0);
    chk("post_cnt",  32'(msg_count),  32'd1);
    chk("post_err",  32'(err_len),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
